// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instruction} buffer between the ICache output
// stage and decode. Fullness drives the fetch stall early enough that the
// SKID in-flight fetches always find room. A redirect (flush) empties the
// queue without touching the storage array.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int SKID  = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready,
   output logic        stall_full_instr,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] STALL_C = (AW+1)'(DEPTH - SKID);

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          push_s, pop_s, valid_s;

   assign valid_s = (count_q != {(AW+1){1'b0}});

   // Handshake decode and next-state for pointers, occupancy and the sticky drop flag.
   always_comb begin
      pop_s      = valid_s & out_ready;
      push_s     = in_valid & ((count_q < FULL_C) | pop_s) & ~flush;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (flush) begin
         // Redirect: empty the queue; a pop in this cycle is not counted.
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s && !pop_s) begin
            count_d = count_q + 1'b1;
         end else if (pop_s && !push_s) begin
            count_d = count_q - 1'b1;
         end else begin
            count_d = count_q;
         end
         // An instruction offered while full and not draining is lost.
         if (in_valid && !push_s) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end
      end
   end

   // Control state registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         count_q    <= {(AW+1){1'b0}};
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage array: written on accepted push, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 64'h0;
         end
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= {in_pc, in_instr};
         end
      end
   end

   assign out_valid        = valid_s;
   assign out_pc           = mem_q[rd_ptr_q][63:32];
   assign out_instr        = mem_q[rd_ptr_q][31:0];
   assign stall_full_instr = (count_q >= STALL_C);
   assign overflow         = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_fetch_queue;

   localparam int DEPTH = 8;
   localparam int SKID  = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = 32'h0;
   logic [31:0] in_instr = 32'h0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready = 1'b0;
   logic        stall_full_instr;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] q_m [$];
   bit          ovf_m = 1'b0;

   fetch_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_ready(out_ready), .stall_full_instr(stall_full_instr),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", out_valid, q_m.size() != 0);
      if (q_m.size() != 0) begin
         chk("out_pc", out_pc, q_m[0][63:32]);
         chk("out_instr", out_instr, q_m[0][31:0]);
      end
      chk("stall", stall_full_instr, q_m.size() >= DEPTH - SKID);
      chk("overflow", overflow, ovf_m);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_valid"}, out_valid, 1'b0);
      chk({tag, "_pc"}, out_pc, 32'h0);
      chk({tag, "_instr"}, out_instr, 32'h0);
      chk({tag, "_stall"}, stall_full_instr, 1'b0);
      chk({tag, "_ovf"}, overflow, 1'b0);
   endtask

   // One clock of stimulus; entered and left at a falling edge.
   task automatic step(input bit fl, input bit iv, input logic [31:0] pc,
                       input logic [31:0] ins, input bit rdy);
      bit pop_m, push_m;
      flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = rdy;
      pop_m  = rdy && (q_m.size() != 0);
      push_m = iv && !fl && ((q_m.size() < DEPTH) || pop_m);
      if (iv && !fl && !push_m) ovf_m = 1'b1;
      @(posedge clk);
      if (fl) begin
         q_m.delete();
      end else begin
         if (pop_m) void'(q_m.pop_front());
         if (push_m) q_m.push_back({pc, ins});
      end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check_outputs();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      q_m.delete();
      ovf_m = 1'b0;
      check_reset_values("reset");
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic push_n(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, base + 32'(4 * i), $urandom, 1'b0);
      end
   endtask

   initial begin
      // Reset and fill: stall at 6, full at 8, overflow on the 9th push.
      do_reset();
      push_n(5, 32'h1c000000);
      chk("stall_at5", stall_full_instr, 1'b0);
      step(1'b0, 1'b1, 32'h1c000014, $urandom, 1'b0);
      chk("stall_at6", stall_full_instr, 1'b1);
      push_n(2, 32'h1c000018);
      chk("ovf_at8", overflow, 1'b0);
      step(1'b0, 1'b1, 32'h1c000020, $urandom, 1'b0);
      chk("ovf_9th", overflow, 1'b1);

      // Drain order: 8 pops, model tracks PC order and stall release.
      do_reset();
      push_n(8, 32'h1c000000);
      for (int i = 0; i < 8; i++) begin
         chk("drain_pc", out_pc, 32'h1c000000 + 32'(4 * i));
         step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      end
      chk("drain_empty", out_valid, 1'b0);

      // Streaming: every push visible exactly one cycle later.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 32'h1c000000 + 32'(4 * i), $urandom, 1'b1);
         chk("stream_pc", out_pc, 32'h1c000000 + 32'(4 * i));
      end

      // Full with simultaneous push and pop.
      do_reset();
      push_n(8, 32'h1c000000);
      step(1'b0, 1'b1, 32'h1c000100, 32'hdeadbeef, 1'b1);
      chk("fullpp_ovf", overflow, 1'b0);
      chk("fullpp_stall", stall_full_instr, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("fullpp_empty", out_valid, 1'b0);

      // Flush with push and pop requested in the same cycle.
      do_reset();
      push_n(5, 32'h1c000000);
      step(1'b1, 1'b1, 32'h1c000040, $urandom, 1'b1);
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_stall", stall_full_instr, 1'b0);
      step(1'b0, 1'b1, 32'h1c008000, 32'h00000013, 1'b0);
      chk("flush_next_pc", out_pc, 32'h1c008000);

      // Random traffic with varying occupancy pressure and occasional flush.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int rbias;
         rbias = (i / 250) % 3;
         step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
              $urandom, $urandom, $urandom_range(0, 2) < rbias);
      end

      // Asynchronous reset mid-operation with overflow set and 4 entries queued.
      do_reset();
      push_n(9, 32'h1c000000);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("pre_rst_valid", out_valid, 1'b1);
      chk("pre_rst_ovf", overflow, 1'b1);
      #2;
      rstn = 1'b0;
      #1;
      q_m.delete();
      ovf_m = 1'b0;
      check_reset_values("async_rst");
      @(negedge clk);
      rstn = 1'b1;
      step(1'b0, 1'b1, 32'h1c000200, $urandom, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
